// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: reset vector, IF stage state encoding, NOP word.
package cpu_defs;

    localparam int unsigned PC_W     = 32;
    localparam int unsigned INST_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam logic [31:0] NOP      = 32'h0;

    typedef enum logic [1:0] {
        IF_REQ  = 2'd0,
        IF_RESP = 2'd1,
        IF_HOLD = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_next_pc.sv
// Next fetch PC select: ex_flush > br_taken > sequential pc+4.
//   ex_flush/ex_target  exception or ertn redirect
//   br_taken/br_target  branch redirect
//   seq_pc              PC of the instruction currently held
//   next_pc_c           selected next fetch address
//   redirect_c          any redirect this cycle
module if_next_pc
    import cpu_defs::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         ex_flush,
    input  logic [W-1:0] ex_target,
    input  logic         br_taken,
    input  logic [W-1:0] br_target,
    input  logic [W-1:0] seq_pc,
    output logic [W-1:0] next_pc_c,
    output logic         redirect_c
);

    assign redirect_c = ex_flush | br_taken;

    always_comb begin
        next_pc_c = seq_pc + W'(4);
        if (ex_flush) begin
            next_pc_c = ex_target;
        end else if (br_taken) begin
            next_pc_c = br_target;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: sequential PC generation, single-outstanding instruction fetch,
// instruction hold until ID accepts, and redirect with in-flight cancel.
//   clk, rst                 clock, async active-high reset
//   id_allowin               ID accepts the presented instruction
//   br_taken/br_target       branch redirect
//   ex_flush/ex_target       exception redirect (wins over branch)
//   inst_sram_*              req/addr_ok/data_ok fetch port
//   fs_valid/fs_pc/fs_inst   IF/ID register inputs
//   fs_fresh                 one-cycle bubble request after a redirect
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
    parameter int unsigned PC_W     = cpu_defs::PC_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_allowin,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            ex_flush,
    input  logic [PC_W-1:0] ex_target,
    output logic            inst_sram_req,
    output logic [PC_W-1:0] inst_sram_addr,
    input  logic            inst_sram_addr_ok,
    input  logic            inst_sram_data_ok,
    input  logic [31:0]     inst_sram_rdata,
    output logic            fs_valid,
    output logic [PC_W-1:0] fs_pc,
    output logic [31:0]     fs_inst,
    output logic            fs_fresh
);
    import cpu_defs::*;

    if_state_e       state_q, state_d;
    logic            cancel_q, cancel_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] fetch_pc_q;
    logic [31:0]     inst_q;
    logic            fresh_q;
    logic            latch_inst;
    logic            advance;
    logic            redirect;
    logic [PC_W-1:0] next_pc;

    if_next_pc #(.W(PC_W)) u_next_pc (
        .ex_flush   (ex_flush),
        .ex_target  (ex_target),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .seq_pc     (pc_q),
        .next_pc_c  (next_pc),
        .redirect_c (redirect)
    );

    // State register and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IF_REQ;
            cancel_q   <= 1'b0;
            pc_q       <= PC_W'(RESET_PC - 32'd4);
            fetch_pc_q <= PC_W'(RESET_PC);
            inst_q     <= NOP;
            fresh_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            fresh_q  <= redirect;
            if (redirect || advance) begin
                fetch_pc_q <= next_pc;
            end
            if (latch_inst) begin
                inst_q <= inst_sram_rdata;
                pc_q   <= fetch_pc_q;
            end
        end
    end

    // Next-state, cancel and load enables
    always_comb begin
        state_d    = state_q;
        cancel_d   = cancel_q;
        latch_inst = 1'b0;
        advance    = 1'b0;
        unique case (state_q)
            IF_REQ: begin
                // A redirect in the accept cycle leaves the old address in flight.
                if (inst_sram_addr_ok) begin
                    state_d  = IF_RESP;
                    cancel_d = redirect;
                end
            end
            IF_RESP: begin
                if (inst_sram_data_ok) begin
                    cancel_d   = 1'b0;
                    latch_inst = !cancel_q && !redirect;
                    state_d    = latch_inst ? IF_HOLD : IF_REQ;
                end else if (redirect) begin
                    cancel_d = 1'b1;
                end
            end
            IF_HOLD: begin
                advance = id_allowin && !redirect;
                if (redirect || id_allowin) begin
                    state_d = IF_REQ;
                end
            end
            default: begin
                state_d  = IF_REQ;
                cancel_d = 1'b0;
            end
        endcase
    end

    assign inst_sram_req  = (state_q == IF_REQ) && !rst;
    assign inst_sram_addr = fetch_pc_q;
    assign fs_valid       = (state_q == IF_HOLD);
    assign fs_pc          = pc_q;
    assign fs_inst        = inst_q;
    assign fs_fresh       = fresh_q;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- IF stage of the 5-stage LoongArch pipeline. Drives the IF/ID register inputs: PC, instruction, write enable and fresh/bubble.
- Generates the sequential PC and fetches from the instruction SRAM-like port (req/addr_ok/data_ok handshake).
- Holds the fetched instruction until ID accepts it.
- Applies branch and exception redirects, cancelling any fetch already in flight.

Parameters:
- RESET_PC, 32'h1c000000, first fetched address after reset.
- PC_W, 32, PC and address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_allowin  in  1  ID can accept an instruction this cycle
- br_taken  in  1  branch redirect request from ID/EX
- br_target  in  PC_W  branch target
- ex_flush  in  1  exception/ertn redirect
- ex_target  in  PC_W  exception entry/return target
- inst_sram_req  out  1  fetch request
- inst_sram_addr  out  PC_W  fetch address
- inst_sram_addr_ok  in  1  address accepted
- inst_sram_data_ok  in  1  read data returned
- inst_sram_rdata  in  32  instruction word
- fs_valid  out  1  fs_pc/fs_inst valid; drives IF/ID we
- fs_pc  out  PC_W  PC of presented instruction
- fs_inst  out  32  presented instruction
- fs_fresh  out  1  one-cycle bubble request; drives IF/ID IF_fresh

Behaviour:
- Reset (async, immediate):
  - state=REQ, pc=RESET_PC-4 (32'h1bfffffc), fetch_pc=RESET_PC.
  - fs_valid=0, fs_inst=0, fs_fresh=0, cancel=0.
  - inst_sram_req=0 while rst is high.
- State REQ:
  - inst_sram_req=1, inst_sram_addr=fetch_pc.
  - On addr_ok: go to RESP.
  - Redirect while still in REQ: fetch_pc is replaced by the target the next cycle. No cancel is needed because no address has been accepted.
- State RESP:
  - req=0; at most one outstanding request.
  - data_ok with cancel=0: latch rdata into fs_inst, set pc=fetch_pc, go to HOLD.
  - data_ok with cancel=1: discard the data, clear cancel, go to REQ.
- State HOLD:
  - fs_valid=1.
  - fs_valid && id_allowin: fetch_pc=pc+4 (mod 2^32, wraps), go to REQ next cycle, fs_valid=0.
- Latency:
  - Request to presentation is addr_ok cycle, then data_ok cycle, then fs_valid the cycle after data_ok.
  - Minimum 3 cycles per instruction; no prefetch.
- Redirect:
  - redirect = ex_flush | br_taken. ex_flush has priority; on simultaneous assertion the target is ex_target.
  - Effect in every state: fetch_pc=target, fs_valid=0 next cycle, fs_fresh=1 for exactly one cycle.
  - In RESP without data_ok the same cycle: set cancel=1.
  - In RESP with data_ok the same cycle: drop the data, cancel stays 0, go to REQ.
  - In HOLD: drop the held instruction, go to REQ.
  - A second redirect while cancel=1 only updates fetch_pc; cancel stays 1, since there is only one outstanding response.
- fs_pc holds its last value when fs_valid=0. fs_pc=32'h1bfffffc until the first instruction completes.
- Misaligned target (addr[1:0]!=0): fetched as-is. ADEF detection belongs to the exception unit, not this block.

Decomposition:
- Shared package (cpu_defs):
  - RESET_PC constant.
  - IF state encoding: REQ=2'd0, RESP=2'd1, HOLD=2'd2.
  - NOP constant 32'h0.
- One natural sub-module: if_next_pc, a combinational next-fetch_pc mux with priority ex_flush > br_taken > pc+4. The FSM, cancel flag and instruction buffer remain in the top.

Test Plan:
- Reset release, memory returns addr_ok immediately and data_ok one cycle later with 32'h02800000, id_allowin=1 -> addr=1c000000, then fs_valid=1 with fs_pc=1c000000 and fs_inst=02800000; next request addr=1c000004.
- id_allowin=0 for 5 cycles while in HOLD -> fs_valid stays 1, fs_pc/fs_inst stable, no new req; release -> next addr=pc+4.
- br_taken to 1c000100 one cycle after addr_ok (RESP), data_ok arrives 2 cycles later -> that data is discarded, fs_fresh pulses once, next req addr=1c000100, fs_valid never shows the cancelled word.
- ex_flush(target 1c008000) and br_taken(target 1c000200) in the same cycle during HOLD -> next req addr=1c008000, held instruction dropped.
- Redirect in the same cycle as data_ok -> no cancel flag set; the following data_ok is accepted and shows fs_pc=target.
- Async rst asserted mid-RESP -> outputs reset without waiting for a clock edge; req restarts at 1c000000; any late data_ok is ignored because state is REQ.
